// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

    localparam logic [31:0] DMEM_ERR_DATA = 32'hDEAD_BEEF;
    localparam int          CNT_W         = 4;
endpackage

// File: rtl/dmem_responder_if.sv
// Core-side data-memory port: request lines from the core, data/stall/error back.
interface dmem_responder_if;
    logic        memread;
    logic        memwrite;
    logic [31:0] memaddr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        cpu_en;
    logic        err;

    modport master (output memread, memwrite, memaddr, writedata,
                    input  readdata, cpu_en, err);
    modport slave  (input  memread, memwrite, memaddr, writedata,
                    output readdata, cpu_en, err);
endinterface

// File: rtl/dmem_sram.sv
// Single-port synchronous word array; read register holds between reads.
module dmem_sram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    logic [31:0] mem [2**ADDR_W];
    logic [31:0] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem[addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder for the MIPS core; stalls via cpu_en.
// Define DMEM_ERR_CHK_EN to flag misaligned/out-of-range accesses on err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            r_st,
    dmem_responder_if.slave bus
);
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req, start, addr_bad, is_rd, is_wr;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       sram_rdata;

    assign req   = bus.memread | bus.memwrite;
    assign start = req && (state_q == IDLE);
    // Simultaneous read+write is a write; readdata must not move.
    assign is_wr = start & bus.memwrite;
    assign is_rd = start & bus.memread & ~bus.memwrite;
    assign idx   = bus.memaddr[ADDR_W+1:2] - BASE_ADDR[ADDR_W+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (req) begin
                if (WAIT_CYCLES > 0) begin
                    state_d = WAIT;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    state_d = DONE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge r_st) begin
        if (r_st) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    dmem_sram #(.ADDR_W(ADDR_W)) u_sram (
        .clk   (clk),
        .rst   (r_st),
        .we    (is_wr & ~addr_bad),
        .re    (is_rd & ~addr_bad),
        .addr  (idx),
        .wdata (bus.writedata),
        .rdata (sram_rdata)
    );

`ifdef DMEM_ERR_CHK_EN
    logic        err_q, err_d;
    logic        rd_err_q, rd_err_d;
    logic [32:0] addr_ext, base_ext, limit_ext;

    assign addr_ext  = {1'b0, bus.memaddr};
    assign base_ext  = {1'b0, BASE_ADDR};
    assign limit_ext = base_ext + (33'd4 << ADDR_W);
    assign addr_bad  = (bus.memaddr[1:0] != 2'b00) ||
                       (addr_ext < base_ext) || (addr_ext >= limit_ext);

    // rd_err_q selects the error pattern until the next read replaces it.
    always_comb begin
        err_d    = err_q | (start & addr_bad);
        rd_err_d = rd_err_q;
        if (is_rd) rd_err_d = addr_bad;
    end

    always_ff @(posedge clk or posedge r_st) begin
        if (r_st) begin
            err_q    <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            err_q    <= err_d;
            rd_err_q <= rd_err_d;
        end
    end

    assign bus.readdata = rd_err_q ? DMEM_ERR_DATA : sram_rdata;
    assign bus.err      = err_q;
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.memaddr[31:ADDR_W+2], bus.memaddr[1:0]};
    assign addr_bad         = 1'b0;
    assign bus.readdata     = sram_rdata;
    assign bus.err          = 1'b0;
`endif

    assign bus.cpu_en = ~r_st & ~start & (state_q != WAIT);
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized/directed bench for dmem_responder: two instances (0 and 2 wait states).
module tb_dmem_responder;
    logic clk  = 1'b0;
    logic r_st = 1'b1;
    always #5 clk = ~clk;

    dmem_responder_if b0 ();
    dmem_responder_if b2 ();

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
        .clk(clk), .r_st(r_st), .bus(b0));
    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut2 (
        .clk(clk), .r_st(r_st), .bus(b2));

    int errors = 0;
    int checks = 0;

    // Reference model, indexed by the instance's wait count (0 or 2).
    logic [31:0] mem0 [int];
    logic [31:0] mem2 [int];
    logic [31:0] exp_rd  [3];
    logic        exp_err [3];
    bit          in_done [3];
    int          known0 [$];
    int          known2 [$];

    function automatic bit addr_ok(input logic [31:0] a);
`ifdef DMEM_ERR_CHK_EN
        return (a[1:0] == 2'b00) && (a < 32'h1000);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 4) % 1024);
    endfunction

    function automatic logic [31:0] get_rd(input int s);
        return (s == 0) ? b0.readdata : b2.readdata;
    endfunction
    function automatic logic get_en(input int s);
        return (s == 0) ? b0.cpu_en : b2.cpu_en;
    endfunction
    function automatic logic get_err(input int s);
        return (s == 0) ? b0.err : b2.err;
    endfunction

    task automatic drive(input int s, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (s == 0) begin
            b0.memread = rd; b0.memwrite = wr; b0.memaddr = a; b0.writedata = d;
        end else begin
            b2.memread = rd; b2.memwrite = wr; b2.memaddr = a; b2.writedata = d;
        end
    endtask

    task automatic model_reset();
        exp_rd[0] = '0; exp_rd[2] = '0;
        exp_err[0] = 1'b0; exp_err[2] = 1'b0;
        in_done[0] = 1'b0; in_done[2] = 1'b0;
    endtask

    // One memory instruction as the core sees it: hold the request until cpu_en rises.
    task automatic access(input int s, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] d, input string nm);
        int lows = 0;
        bit done = 1'b0;
        logic [31:0] rd_first = '0;
        int w;
        drive(s, rd, wr, a, d);
        if (in_done[s]) @(negedge clk);
        else            #1;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c == 1) rd_first = get_rd(s);
            if (get_en(s) === 1'b1) done = 1'b1;
            else begin
                lows++;
                @(negedge clk);
            end
        end
        in_done[s] = 1'b1;
        if (wr) begin
            if (addr_ok(a)) begin
                w = word_of(a);
                if (s == 0) begin mem0[w] = d; known0.push_back(w); end
                else        begin mem2[w] = d; known2.push_back(w); end
            end else exp_err[s] = 1'b1;
        end else if (rd) begin
            if (addr_ok(a)) begin
                w = word_of(a);
                exp_rd[s] = (s == 0) ? mem0[w] : mem2[w];
            end else begin
                exp_rd[s]  = 32'hDEAD_BEEF;
                exp_err[s] = 1'b1;
            end
        end
        checks++;
        if (!done || lows != s + 1) begin
            errors++;
            $display("FAIL %s stall: got %0d low cycles (done=%0b), want %0d", nm, lows, done, s + 1);
        end
        if (rd && !wr) begin
            checks++;
            if (rd_first !== exp_rd[s]) begin
                errors++;
                $display("FAIL %s early readdata: got %h want %h", nm, rd_first, exp_rd[s]);
            end
        end
        checks++;
        if (get_rd(s) !== exp_rd[s]) begin
            errors++;
            $display("FAIL %s readdata: got %h want %h", nm, get_rd(s), exp_rd[s]);
        end
        checks++;
        if (get_err(s) !== exp_err[s]) begin
            errors++;
            $display("FAIL %s err: got %b want %b", nm, get_err(s), exp_err[s]);
        end
    endtask

    // Non-memory instructions: cpu_en must stay high every cycle.
    task automatic idle(input int s, input int n, input string nm);
        drive(s, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (get_en(s) !== 1'b1) begin
                errors++;
                $display("FAIL %s idle cpu_en cycle %0d: got %b want 1", nm, i, get_en(s));
            end
        end
        in_done[s] = 1'b0;
    endtask

    task automatic test_reset();
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(2, 1'b1, 1'b0, 32'h10, '0);
        r_st = 1'b1;
        model_reset();
        @(negedge clk); @(negedge clk);
        checks++;
        if (b0.readdata !== 32'h0 || b2.readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset readdata: got %h/%h want 0", b0.readdata, b2.readdata);
        end
        checks++;
        if (b0.err !== 1'b0 || b2.err !== 1'b0) begin
            errors++;
            $display("FAIL reset err: got %b/%b want 0", b0.err, b2.err);
        end
        checks++;
        if (b0.cpu_en !== 1'b0 || b2.cpu_en !== 1'b0) begin
            errors++;
            $display("FAIL reset cpu_en: got %b/%b want 0", b0.cpu_en, b2.cpu_en);
        end
        drive(2, 1'b0, 1'b0, '0, '0);
        r_st = 1'b0;
        idle(0, 1, "reset_release0");
        idle(2, 1, "reset_release2");
    endtask

    task automatic test_wait2();
        access(2, 1'b0, 1'b1, 32'h10, 32'h1234_5678, "w2_sw");
        idle(2, 1, "w2_gap");
        access(2, 1'b1, 1'b0, 32'h10, '0, "w2_lw");
        idle(2, 1, "w2_end");
        checks++;
        if (b2.readdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL w2_value: got %h want 12345678", b2.readdata);
        end
    endtask

    task automatic test_back_to_back();
        access(0, 1'b0, 1'b1, 32'h20, 32'h0BAD_F00D, "b2b_sw");
        access(0, 1'b1, 1'b0, 32'h20, '0, "b2b_lw");
        idle(0, 2, "b2b_add");
        access(0, 1'b0, 1'b1, 32'h24, 32'h7777_1111, "b2b_sw2");
        access(0, 1'b1, 1'b0, 32'h20, '0, "b2b_lw2");
        idle(0, 1, "b2b_end");
    endtask

    task automatic test_rw_both();
        access(2, 1'b1, 1'b1, 32'h04, 32'hCAFE_0001, "rw_both");
        idle(2, 1, "rw_gap");
        access(2, 1'b1, 1'b0, 32'h04, '0, "rw_readback");
        idle(2, 1, "rw_end");
    endtask

    // Error cases; without the check these exercise aliasing through the same model.
    task automatic test_err();
        access(2, 1'b0, 1'b1, 32'h00, 32'hA5A5_0000, "err_setup");
        idle(2, 1, "err_gap0");
        access(2, 1'b1, 1'b0, 32'h13, '0, "err_misaligned_rd");
        idle(2, 1, "err_gap1");
        access(2, 1'b0, 1'b1, 32'h1000, 32'h5A5A_FFFF, "err_range_wr");
        idle(2, 1, "err_gap2");
        access(2, 1'b1, 1'b0, 32'h00, '0, "err_word0");
        idle(2, 1, "err_gap3");
        access(2, 1'b1, 1'b0, 32'h10, '0, "err_sticky");
        idle(2, 1, "err_end");
    endtask

    task automatic test_reset_mid();
        logic [31:0] d = 32'h0808_ABCD;
        drive(2, 1'b0, 1'b1, 32'h08, d);
        @(posedge clk);
        @(negedge clk);
        r_st = 1'b1;
        mem2[2] = d;
        known2.push_back(2);
        model_reset();
        #1;
        checks++;
        if (b2.cpu_en !== 1'b0 || b0.cpu_en !== 1'b0) begin
            errors++;
            $display("FAIL rstmid cpu_en: got %b/%b want 0", b2.cpu_en, b0.cpu_en);
        end
        checks++;
        if (b2.readdata !== 32'h0 || b2.err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid outputs: readdata %h err %b want 0/0", b2.readdata, b2.err);
        end
        drive(2, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        r_st = 1'b0;
        idle(2, 1, "rstmid_release");
        access(2, 1'b1, 1'b0, 32'h08, '0, "rstmid_readback");
        idle(2, 1, "rstmid_end");
    endtask

    task automatic test_random(input int s);
        logic [31:0] a;
        int w;
        int gap;
        for (int i = 0; i < 14; i++) begin
            int nk = (s == 0) ? known0.size() : known2.size();
            if (nk == 0 || $urandom_range(1, 0) == 1) begin
                w = 64 + $urandom_range(15, 0);
                a = {20'h0, w[9:0], 2'b00};
`ifndef DMEM_ERR_CHK_EN
                a = {$urandom_range(32'hF_FFFF, 0) & 32'hF_FFFF, w[9:0], 2'($urandom_range(3, 0))};
`endif
                access(s, 1'b0, 1'b1, a, $urandom, "rand_wr");
            end else begin
                w = (s == 0) ? known0[$urandom_range(nk - 1, 0)] : known2[$urandom_range(nk - 1, 0)];
                a = {20'h0, w[9:0], 2'b00};
`ifndef DMEM_ERR_CHK_EN
                a = {$urandom_range(32'hF_FFFF, 0) & 32'hF_FFFF, w[9:0], 2'($urandom_range(3, 0))};
`endif
                access(s, 1'b1, 1'b0, a, '0, "rand_rd");
            end
            gap = $urandom_range(2, 0);
            if (gap > 0) idle(s, gap, "rand_gap");
        end
        idle(s, 1, "rand_end");
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(2, 1'b0, 1'b0, '0, '0);
        test_reset();
        test_wait2();
        test_back_to_back();
        test_rw_both();
        test_err();
        test_reset_mid();
        test_random(2);
        test_random(0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
